// File: rtl/sdp_wr_arb_if.sv
// Valid/ready stream carrying one packed word from a producer to a consumer.
// A transfer happens on a posedge where valid and ready are both 1; while
// valid=1 and ready=0 the producer holds data stable; ready may depend
// combinationally on valid.
interface dti #(
    parameter int W = 32
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport producer (output valid, output data, input ready);
    modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/sdp_wr_arb.sv
// Two-requester write arbiter for a simple-dual-port memory: round-robin
// with optional burst lock, one register stage to the memory write port.
module sdp_wr_arb #(
    parameter int W_DATA    = 16,
    parameter int W_ADDR    = 16,
    parameter int BURST_LEN = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    dti.consumer                               din0,
    dti.consumer                               din1,
    output logic                               en_o,
    output logic [W_ADDR-1:0]                  addr_o,
    output logic [W_DATA-1:0]                  data_o,
    output logic                               o_dbg_last,
    output logic                               o_dbg_owner,
    output logic [$clog2(BURST_LEN+1)-1:0]     o_dbg_cnt
);
    localparam int CW = $clog2(BURST_LEN + 1);

    logic                       r_last;
    logic                       r_owner;
    logic [CW-1:0]              r_cnt;
    logic                       w_v0;
    logic                       w_v1;
    logic                       w_locked;
    logic                       w_gnt;
    logic                       w_g;
    logic [W_DATA+W_ADDR-1:0]   w_sel;

    // Requests are masked during reset so neither producer sees ready.
    assign w_v0     = din0.valid & ~rst;
    assign w_v1     = din1.valid & ~rst;
    assign w_locked = (r_cnt != '0) && (r_owner ? w_v1 : w_v0);

    always_comb begin
        w_gnt = 1'b0;
        w_g   = 1'b0;
        if (w_locked) begin
            w_gnt = 1'b1;
            w_g   = r_owner;
        end else if (w_v0 && w_v1) begin
            w_gnt = 1'b1;
            w_g   = ~r_last;
        end else if (w_v0) begin
            w_gnt = 1'b1;
            w_g   = 1'b0;
        end else if (w_v1) begin
            w_gnt = 1'b1;
            w_g   = 1'b1;
        end
    end

    assign din0.ready = w_gnt & ~w_g;
    assign din1.ready = w_gnt &  w_g;
    assign w_sel      = w_g ? din1.data : din0.data;

    always_ff @(posedge clk) begin
        if (rst) begin
            en_o    <= 1'b0;
            addr_o  <= '0;
            data_o  <= '0;
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_cnt   <= '0;
        end else begin
            en_o <= w_gnt;
            if (w_gnt) begin
                addr_o <= w_sel[W_ADDR-1:0];
                data_o <= w_sel[W_ADDR +: W_DATA];
                r_last <= w_g;
                // A void lock (owner dropped valid) counts as a fresh grant.
                if (w_locked) begin
                    r_cnt <= r_cnt - CW'(1);
                end else begin
                    r_owner <= w_g;
                    r_cnt   <= CW'(BURST_LEN - 1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_dbg_last  = r_last;
    assign o_dbg_owner = r_owner;
    assign o_dbg_cnt   = r_cnt;
endmodule
